// File: rtl/ula_arbitro.sv
// -----------------------------------------------------------------------------
// ula_arbitro
// Round-robin arbiter that lets two requesters share one 8-bit ALU.
// It keeps one operation in flight at a time:
//   - It accepts (A, B, opcode) on a valid/ready handshake.
//   - It holds the operands on the ALU inputs.
//   - It waits LATENCIA cycles.
//   - It returns the 9-bit ALU result on a per-requester response handshake.
//
// Parameter
//   LATENCIA       register stages inside the ALU (0 = combinational), 0..7
//
// Build option
//   ULA_ARBITRO_OPCHECK_EN
//      Adds the resp_erro output.
//      Opcodes 12..15 are answered directly with 9'h1FF and resp_erro=1,
//      without touching the ALU.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   req_valid[i]   requester i has an operation pending
//   req_a/req_b    operands, requester i on bits [8i+7:8i]
//   req_op         opcodes, requester i on bits [4i+3:4i]
//   req_ready[i]   operation of requester i accepted this cycle (one-hot/zero)
//   resp_valid[i]  resp_data holds the result for requester i
//   resp_data      9-bit result, shared by both requesters
//   resp_ready[i]  requester i consumes the response
//   ula_a/b/op     operands and opcode driven to the ALU
//   ula_resultado  9-bit result coming back from the ALU
//   ocupado        high whenever the arbiter is not idle
//   resp_erro      (option only) illegal opcode flag, valid with resp_valid
// -----------------------------------------------------------------------------
module ula_arbitro #(
   parameter int unsigned LATENCIA = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [7:0]  req_op,
   output logic [1:0]  req_ready,
   output logic [1:0]  resp_valid,
   output logic [8:0]  resp_data,
   input  logic [1:0]  resp_ready,
   output logic [7:0]  ula_a,
   output logic [7:0]  ula_b,
   output logic [3:0]  ula_op,
   input  logic [8:0]  ula_resultado,
   output logic        ocupado
`ifdef ULA_ARBITRO_OPCHECK_EN
  ,output logic        resp_erro
`endif
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPONDE = 2'd2
   } estado_t;

   localparam logic [2:0] LAT_INI = 3'(LATENCIA);

   estado_t    r_estado;
   estado_t    w_estado_next;
   logic       r_ultimo;      // requester served last, loses the next tie
   logic       r_g;           // requester owning the operation in flight
   logic [2:0] r_cont;        // remaining ALU wait cycles
   logic [7:0] r_ula_a;
   logic [7:0] r_ula_b;
   logic [3:0] r_ula_op;
   logic [8:0] r_resp_data;

   logic [7:0] w_a  [2];
   logic [7:0] w_b  [2];
   logic [3:0] w_op [2];
   logic       w_g;
   logic       w_aceita;
   logic       w_op_ilegal;

   // Split the packed request buses into one lane per requester.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign w_a[gi]  = req_a[8*gi +: 8];
         assign w_b[gi]  = req_b[8*gi +: 8];
         assign w_op[gi] = req_op[4*gi +: 4];
      end
   endgenerate

   // Grant: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      w_g = 1'b0;
      case (req_valid)
         2'b01:   w_g = 1'b0;
         2'b10:   w_g = 1'b1;
         2'b11:   w_g = ~r_ultimo;
         default: w_g = 1'b0;
      endcase
   end

   assign w_aceita = (r_estado == OCIOSO) && (|req_valid);

`ifdef ULA_ARBITRO_OPCHECK_EN
   assign w_op_ilegal = (w_op[w_g] >= 4'd12);
`else
   assign w_op_ilegal = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_estado_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_estado_next = r_estado;
      case (r_estado)
         OCIOSO: begin
            if (w_aceita) begin
               // Illegal opcodes skip the ALU and answer immediately.
               w_estado_next = w_op_ilegal ? RESPONDE : EXECUTA;
            end
         end
         EXECUTA: begin
            if (r_cont == 3'd0) begin
               w_estado_next = RESPONDE;
            end
         end
         RESPONDE: begin
            if (resp_ready[r_g]) begin
               w_estado_next = OCIOSO;
            end
         end
         default: w_estado_next = OCIOSO;
      endcase
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ultimo    <= 1'b1;
         r_g         <= 1'b0;
         r_cont      <= 3'd0;
         r_ula_a     <= 8'd0;
         r_ula_b     <= 8'd0;
         r_ula_op    <= 4'd0;
         r_resp_data <= 9'd0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (w_aceita) begin
                  r_g    <= w_g;
                  r_cont <= LAT_INI;
                  if (w_op_ilegal) begin
                     r_resp_data <= 9'h1FF;
                  end else begin
                     r_ula_a  <= w_a[w_g];
                     r_ula_b  <= w_b[w_g];
                     r_ula_op <= w_op[w_g];
                  end
               end
            end
            EXECUTA: begin
               // Counter reaching zero marks the edge where the ALU output is valid.
               if (r_cont != 3'd0) begin
                  r_cont <= r_cont - 3'd1;
               end else begin
                  r_resp_data <= ula_resultado;
               end
            end
            RESPONDE: begin
               if (resp_ready[r_g]) begin
                  r_ultimo <= r_g;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ULA_ARBITRO_OPCHECK_EN
   logic r_erro;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_erro <= 1'b0;
      end else if (w_aceita) begin
         r_erro <= w_op_ilegal;
      end
   end

   assign resp_erro = r_erro && (r_estado == RESPONDE);
`endif

   // ------------------------------------------------------------------ outputs
   always_comb begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      ocupado    = 1'b1;
      case (r_estado)
         OCIOSO: begin
            ocupado = 1'b0;
            if (|req_valid) begin
               req_ready = w_g ? 2'b10 : 2'b01;
            end
         end
         RESPONDE: begin
            resp_valid = r_g ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   assign ula_a     = r_ula_a;
   assign ula_b     = r_ula_b;
   assign ula_op    = r_ula_op;
   assign resp_data = r_resp_data;

endmodule

// File: tb/tb_ula_arbitro.sv
module tb_ula_arbitro;

   localparam int LAT = 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic [7:0]  req_op = '0;
   logic [1:0]  req_ready;
   logic [1:0]  resp_valid;
   logic [8:0]  resp_data;
   logic [1:0]  resp_ready = '0;
   logic [7:0]  ula_a;
   logic [7:0]  ula_b;
   logic [3:0]  ula_op;
   logic [8:0]  ula_resultado;
   logic        ocupado;
`ifdef ULA_ARBITRO_OPCHECK_EN
   logic        resp_erro;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   ula_arbitro #(.LATENCIA(LAT)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_op        (req_op),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_ready    (resp_ready),
      .ula_a         (ula_a),
      .ula_b         (ula_b),
      .ula_op        (ula_op),
      .ula_resultado (ula_resultado),
      .ocupado       (ocupado)
`ifdef ULA_ARBITRO_OPCHECK_EN
     ,.resp_erro     (resp_erro)
`endif
   );

   // Simple ALU stand-in with LAT register stages.
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0:    alu_f = {1'b0, a} + {1'b0, b};
         4'd1:    alu_f = {1'b0, a} - {1'b0, b};
         4'd2:    alu_f = {8'd0, a > b};
         4'd3:    alu_f = {8'd0, a < b};
         4'd6:    alu_f = {8'd0, a == b};
         4'd8:    alu_f = {1'b0, a & b};
         4'd9:    alu_f = {1'b0, a | b};
         4'd10:   alu_f = {1'b0, a ^ b};
         default: alu_f = 9'd0;
      endcase
   endfunction

   logic [8:0] alu_pipe [0:7];
   always_ff @(posedge clock) begin
      alu_pipe[0] <= alu_f(ula_a, ula_b, ula_op);
      for (int i = 1; i < 8; i++) alu_pipe[i] <= alu_pipe[i-1];
   end

   generate
      if (LAT == 0) begin : g_alu_comb
         assign ula_resultado = alu_f(ula_a, ula_b, ula_op);
      end else begin : g_alu_pipe
         assign ula_resultado = alu_pipe[LAT-1];
      end
   endgenerate

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Issue one operation from requester r (which must win the grant) and
   // consume its response after 'stall' cycles of backpressure.
   task automatic serve(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [8:0] exp, input int stall);
      logic [1:0] oh;
      oh = 2'b01 << r;
      req_a[8*r +: 8] = a;
      req_b[8*r +: 8] = b;
      req_op[4*r +: 4] = op;
      req_valid[r] = 1'b1;
      #1;
      check_eq("req_ready_grant", 32'(req_ready), 32'(oh));
      @(posedge clock); #1;
      req_valid[r] = 1'b0;
      check_eq("ula_a", 32'(ula_a), 32'(a));
      check_eq("ula_b", 32'(ula_b), 32'(b));
      check_eq("ula_op", 32'(ula_op), 32'(op));
      check_eq("ocupado_exec", 32'(ocupado), 32'd1);
      for (int i = 0; i < LAT; i++) begin
         @(posedge clock); #1;
         check_eq("resp_valid_early", 32'(resp_valid), 32'd0);
      end
      @(posedge clock); #1;
      check_eq("resp_valid", 32'(resp_valid), 32'(oh));
      check_eq("resp_data", 32'(resp_data), 32'(exp));
`ifdef ULA_ARBITRO_OPCHECK_EN
      check_eq("resp_erro_legal", 32'(resp_erro), 32'd0);
`endif
      for (int i = 0; i < stall; i++) begin
         resp_ready = ~oh;   // the other requester's ready must be ignored
         @(posedge clock); #1;
         check_eq("stall_resp_valid", 32'(resp_valid), 32'(oh));
         check_eq("stall_resp_data", 32'(resp_data), 32'(exp));
         check_eq("stall_req_ready", 32'(req_ready), 32'd0);
         check_eq("stall_ocupado", 32'(ocupado), 32'd1);
      end
      resp_ready = oh;
      @(posedge clock); #1;
      resp_ready = 2'b00;
      check_eq("resp_valid_done", 32'(resp_valid), 32'd0);
      check_eq("ocupado_idle", 32'(ocupado), 32'd0);
      $display("txn req%0d op=%0d a=%0d b=%0d -> resp_data=0x%03h (expected 0x%03h)",
               r, op, a, b, resp_data, exp);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check_eq("rst_ocupado", 32'(ocupado), 32'd0);
      check_eq("rst_resp_data", 32'(resp_data), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_data", 32'(resp_data), 32'd0);
      check_eq("rst_ula_a", 32'(ula_a), 32'd0);
      check_eq("rst_ula_b", 32'(ula_b), 32'd0);
      check_eq("rst_ula_op", 32'(ula_op), 32'd0);
      check_eq("rst_ocupado", 32'(ocupado), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Basic add, response held for 2 cycles
      serve(0, 8'd9, 8'd20, 4'd0, 9'd29, 2);
      // Carry out and borrow-free subtraction on requester 1
      serve(1, 8'd255, 8'd255, 4'd0, 9'h1FE, 0);
      serve(1, 8'd255, 8'd255, 4'd1, 9'h000, 0);

`ifdef ULA_ARBITRO_OPCHECK_EN
      // Illegal opcode: answered at E0+1, ALU inputs untouched
      req_a[7:0] = 8'd5; req_b[7:0] = 8'd6; req_op[3:0] = 4'd13; req_valid[0] = 1'b1;
      #1;
      check_eq("ilg_req_ready", 32'(req_ready), 32'd1);
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      check_eq("ilg_resp_valid", 32'(resp_valid), 32'd1);
      check_eq("ilg_resp_data", 32'(resp_data), 32'h1FF);
      check_eq("ilg_resp_erro", 32'(resp_erro), 32'd1);
      check_eq("ilg_ula_op", 32'(ula_op), 32'd1);
      check_eq("ilg_ula_a", 32'(ula_a), 32'd255);
      resp_ready = 2'b01;
      @(posedge clock); #1;
      resp_ready = 2'b00;
      check_eq("ilg_resp_valid_done", 32'(resp_valid), 32'd0);
      check_eq("ilg_resp_erro_done", 32'(resp_erro), 32'd0);
      $display("txn req0 op=13 illegal -> resp_data=0x%03h (expected 0x1ff)", resp_data);
      serve(0, 8'hAA, 8'h55, 4'd10, 9'h0FF, 0);
`endif

      // Contention from reset: req0 first, with 5 cycles backpressure
      apply_reset();
      req_a = {8'd50, 8'd80}; req_b = {8'd50, 8'd70}; req_op = {4'd6, 4'd2};
      req_valid = 2'b11;
      serve(0, 8'd80, 8'd70, 4'd2, 9'd1, 5);
      serve(1, 8'd50, 8'd50, 4'd6, 9'd1, 0);
      // Both again: req1 was served last, so req0 wins
      req_valid = 2'b11;
      serve(0, 8'd80, 8'd70, 4'd2, 9'd1, 0);
      // Both again: now req0 was last, so req1 wins
      req_valid[0] = 1'b1;
      serve(1, 8'd50, 8'd50, 4'd6, 9'd1, 0);
      serve(0, 8'd200, 8'd100, 4'd0, 9'h12C, 0);
      req_valid = 2'b00;

      // Reset in the middle of EXECUTA (ultimo=0 here)
      req_a[15:8] = 8'd7; req_b[15:8] = 8'd3; req_op[7:4] = 4'd0; req_valid[1] = 1'b1;
      #1;
      check_eq("mid_req_ready", 32'(req_ready), 32'd2);
      @(posedge clock); #1;
      req_valid[1] = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check_eq("mid_req_ready_rst", 32'(req_ready), 32'd0);
      check_eq("mid_resp_valid_rst", 32'(resp_valid), 32'd0);
      check_eq("mid_resp_data_rst", 32'(resp_data), 32'd0);
      check_eq("mid_ula_a_rst", 32'(ula_a), 32'd0);
      check_eq("mid_ula_b_rst", 32'(ula_b), 32'd0);
      check_eq("mid_ocupado_rst", 32'(ocupado), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      check_eq("mid_no_response", 32'(resp_valid), 32'd0);
      reset_n = 1'b1;
      // After release req0 must win the tie again
      req_a = {8'd7, 8'd16}; req_b = {8'd3, 8'd1}; req_op = {4'd0, 4'd9};
      req_valid = 2'b11;
      serve(0, 8'd16, 8'd1, 4'd9, 9'd17, 0);
      serve(1, 8'd7, 8'd3, 4'd0, 9'd10, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
- Arbitrates between two requesters that share one 8-bit ALU (ops 0–11: add, sub, comparisons, bitwise), with a 9-bit result.
- Each requester sends an operation (A, B, opcode) on a valid/ready handshake. The block registers it, drives the ALU, waits a fixed ALU latency, then returns the 9-bit result on a per-requester response handshake.
- Arbitration is round-robin, with one operation in flight at a time. The block sits between the instruction-issue logic and the ALU.

Parameters:
- LATENCIA, 1, number of register stages inside the ALU (0 = combinational ALU); range 0..7.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i = requester i has an operation pending.
- req_a  in  16  operand A; requester i on bits [8i+7:8i].
- req_b  in  16  operand B; same packing as req_a.
- req_op  in  8  opcode; requester i on bits [4i+3:4i].
- req_ready  out  2  bit i = operation of requester i accepted this cycle.
- resp_valid  out  2  bit i = resp_data holds the result for requester i.
- resp_data  out  9  result, shared by both requesters.
- resp_ready  in  2  bit i = requester i consumes the response.
- ula_a  out  8  operand A to the ALU.
- ula_b  out  8  operand B to the ALU.
- ula_op  out  4  opcode to the ALU.
- ula_resultado  in  9  result from the ALU.
- ocupado  out  1  high in every state except OCIOSO.

Behaviour:
- Clock is "clock". Reset is asynchronous, active-low, on reset_n; the polarity and synchronicity are fixed.
- Reset values:
  - state = OCIOSO; ultimo = 1, so requester 0 wins first.
  - req_ready = 0, resp_valid = 0, resp_data = 0.
  - ula_a = ula_b = 0, ula_op = 0, ocupado = 0, wait counter = 0.
- States: OCIOSO, EXECUTA, RESPONDE.
- OCIOSO:
  - Grant g is computed combinationally. If only one req_valid bit is set, g is that requester. If both are set, g = ~ultimo.
  - req_ready[g] = 1 in the same cycle; req_ready is always one-hot or zero.
  - On the handshake edge (E0): capture A, B, op of g into ula_a/ula_b/ula_op; store g; counter = LATENCIA; go to EXECUTA.
  - If no request is pending, stay in OCIOSO and hold all outputs.
- EXECUTA:
  - ula_* outputs are held stable.
  - The counter decrements each cycle while non-zero.
  - On the edge where the counter is 0, capture ula_resultado into resp_data and go to RESPONDE.
  - Net timing: the result is sampled at edge E0+LATENCIA+1, and resp_valid is high from that edge.
- RESPONDE:
  - resp_valid[g] = 1 and resp_data is held.
  - On the edge where resp_ready[g] = 1: ultimo = g, resp_valid = 0, go to OCIOSO.
  - resp_ready of the other requester is ignored.
- Minimum spacing between acceptances is LATENCIA+3 cycles.
- No new request is accepted outside OCIOSO; req_ready = 0 there.
- Requesters hold req_valid and operands stable until req_ready. Behaviour is undefined if a requester drops them early.
- Fairness: a requester that stays valid is granted within 2 acceptances.
- Width rules:
  - resp_data is ula_resultado copied verbatim (9 bits, including carry/borrow bit 8). No arithmetic is done in this block.
  - Opcodes are forwarded unchanged.
- Reset asserted mid-operation aborts at once. All values return to reset values, and the in-flight result is discarded with no response.

Optional Feature:
- Macro ULA_ARBITRO_OPCHECK_EN.
- When defined:
  - Extra output resp_erro (1 bit, reset 0).
  - Opcodes 12..15 are still accepted. The ALU outputs are not updated, and the block goes directly OCIOSO -> RESPONDE on E0.
  - resp_data = 9'h1FF and resp_erro = 1 while resp_valid is high.
  - resp_erro = 0 for legal opcodes.
- When not defined: the port does not exist, and all 16 opcodes are forwarded to the ALU and timed identically.

Test Plan:
- Reset, LATENCIA=1: req0 A=9, B=20, op=0 -> req_ready=2'b01 for 1 cycle; ula_a=9, ula_b=20 after E0; resp_valid=2'b01 with resp_data=29 at E0+2; held until resp_ready[0].
- Overflow/sub: req1 op=0, 255+255 -> resp_data=9'h1FE. Then req1 op=1, 255-255 -> resp_data=0. resp_valid bit 1 only.
- Contention: both valid from reset with ops (op=2, 80,70) and (op=6, 50,50) -> req0 served first with result 1, then req1 with result 1. Then both valid again -> req0 first again (ultimo=1 after req1 was served).
- Backpressure: hold resp_ready=0 for 5 cycles in RESPONDE -> resp_valid and resp_data stable, req_ready stays 0 although req1 is valid, ocupado=1.
- Reset mid-EXECUTA: drop reset_n one cycle after E0 -> all outputs 0 asynchronously; no response issued; the first request after release is granted to req0.
- With ULA_ARBITRO_OPCHECK_EN: req0 op=13 -> resp_valid at E0+1, resp_data=9'h1FF, resp_erro=1, ula_op unchanged. Then op=10, 0xAA^0x55 -> resp_data=0x0FF, resp_erro=0.
